// File: rtl/mstd_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Fixed latency of WIDTH+2 cycles (2 cycles for divide special cases), with a BUSY stall and a DONE pulse.
module mstd_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       FUN3,
  input  logic [WIDTH-1:0] RS1,
  input  logic [WIDTH-1:0] RS2,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } state_e;

  state_e state_q, state_d;

  logic [2:0]         fun3_q, fun3_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;   // dividend / multiplicand; the quotient shifts in here
  logic [WIDTH-1:0]   op_b_q, op_b_d;   // divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;     // product; the multiplier occupies the low half
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode and the special cases detected in PREP
  logic             is_div;
  logic             rs1_signed;
  logic             rs2_signed;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;
  logic             div_ovf;
  logic             prep_special;

  assign is_div       = fun3_q[2];
  assign rs1_signed   = (fun3_q inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign rs2_signed   = (fun3_q inside {3'b001, 3'b100, 3'b110});
  assign neg1         = rs1_signed & op_a_q[WIDTH-1];
  assign neg2         = rs2_signed & op_b_q[WIDTH-1];
  assign mag_a        = neg1 ? -op_a_q : op_a_q;
  assign mag_b        = neg2 ? -op_b_q : op_b_q;
  assign div_zero     = is_div && (op_b_q == '0);
  assign div_ovf      = is_div && !fun3_q[0] &&
                        (op_a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_q == '1);
  assign prep_special = div_zero | div_ovf;

  // One iteration step of each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_sub;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_a_q} : '0);
  assign div_shift = {rem_q, op_a_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {2'b00, op_b_q});
  assign div_sub   = div_shift[WIDTH:0] - {1'b0, op_b_q};

  // Sign correction and result selection
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   remv;
  logic [WIDTH-1:0]   fix_result;

  assign res_neg = sign1_q ^ sign2_q;
  assign prod    = res_neg ? -acc_q : acc_q;
  assign quot    = res_neg ? -op_a_q : op_a_q;
  assign remv    = sign1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    unique case (fun3_q)
      3'b000:                 fix_result = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = quot;
      default:                fix_result = remv;
    endcase
  end

  // State register
  // NOTE: clocked state is assigned with <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (START && !FLUSH) state_d = S_PREP;
      S_PREP: state_d = prep_special ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (FLUSH && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    BUSY   = (state_q != S_IDLE);
    DONE   = done_q;
    RESULT = result_q;
  end

  // Datapath next-state
  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    fun3_d   = fun3_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) begin
          fun3_d = FUN3;
          op_a_d = RS1;
          op_b_d = RS2;
        end
      end
      S_PREP: begin
        cnt_d = CW'(WIDTH);
        if (div_zero) begin
          // Special results bypass sign correction by clearing both flags
          op_a_d  = '1;
          rem_d   = {1'b0, op_a_q};
          sign1_d = 1'b0;
          sign2_d = 1'b0;
        end else if (div_ovf) begin
          op_a_d  = {1'b1, {(WIDTH-1){1'b0}}};
          rem_d   = '0;
          sign1_d = 1'b0;
          sign2_d = 1'b0;
        end else begin
          op_a_d  = mag_a;
          op_b_d  = mag_b;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          rem_d   = '0;
          sign1_d = neg1;
          sign2_d = neg2;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          rem_d  = div_ge ? div_sub : div_shift[WIDTH:0];
          op_a_d = {op_a_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (!FLUSH) begin
          done_d   = 1'b1;
          result_d = fix_result;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fun3_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      fun3_q   <= fun3_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mstd_unit.sv
// Self-checking bench for mstd_unit: a scoreboard of expected results and DONE edges,
// filled when ops are issued and drained by a DONE monitor.
module tb_mstd_unit;
  localparam int W = 32;

  logic         CLK   = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         FLUSH = 1'b0;
  logic [2:0]   FUN3  = 3'd0;
  logic [W-1:0] RS1   = '0;
  logic [W-1:0] RS2   = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] res;
    int           edge_n;
    logic [2:0]   f;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_result = '0;

  mstd_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FUN3(FUN3), .RS1(RS1), .RS2(RS2),
    .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic is_special(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    return f[2] && ((b == '0) || (!f[0] && (a == 32'h8000_0000) && (b == '1)));
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sbs, ubs, ps;
    logic [2*W-1:0]        pu;
    logic signed [W-1:0]   qa, qb, qs;
    sa  = {{W{a[W-1]}}, a};
    sbs = {{W{b[W-1]}}, b};
    ubs = {{W{1'b0}}, b};
    pu  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    qa  = a;
    qb  = b;
    case (f)
      3'b000: begin ps = sa * sbs; return ps[W-1:0]; end
      3'b001: begin ps = sa * sbs; return ps[2*W-1:W]; end
      3'b010: begin ps = sa * ubs; return ps[2*W-1:W]; end
      3'b011: return pu[2*W-1:W];
      3'b100: begin
        if (b == '0) return '1;
        if (a == 32'h8000_0000 && b == '1) return 32'h8000_0000;
        qs = qa / qb;
        return qs;
      end
      3'b101: return (b == '0) ? '1 : a / b;
      3'b110: begin
        if (b == '0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        qs = qa % qb;
        return qs;
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // DONE monitor: pops the scoreboard and checks value and arrival edge
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && DONE) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: DONE=1 at edge %0d, RESULT=%h, required no DONE", cyc, RESULT);
      end else begin
        e = sb.pop_front();
        last_result = e.res;
        if (RESULT !== e.res || cyc != e.edge_n) begin
          failures++;
          $display("FAIL done_fun3_%0d: RESULT=%h at edge %0d, required %h at edge %0d",
                   e.f, RESULT, cyc, e.res, e.edge_n);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    FUN3  = f;
    RS1   = a;
    RS2   = b;
    START = 1'b1;
    e.res    = ref_op(f, a, b);
    e.edge_n = cyc + 1 + (is_special(f, a, b) ? 2 : W + 2);
    e.f      = f;
    sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    FUN3  = 3'($urandom_range(7));
    RS1   = $urandom;
    RS2   = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_expect(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] req, input string name);
    issue(f, a, b);
    wait_idle();
    checks++;
    if (RESULT !== req) begin
      failures++;
      $display("FAIL %s: RESULT=%h, required %h", name, RESULT, req);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_outputs: BUSY=%b DONE=%b RESULT=%h, required 0 0 0", BUSY, DONE, RESULT);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: BUSY=%b DONE=%b RESULT=%h, required 0 0 0", BUSY, DONE, RESULT);
    end
  endtask

  task automatic test_mul_timing();
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    for (int k = 1; k <= 34; k++) begin
      @(negedge CLK);
      checks++;
      if (k < 34 && (BUSY !== 1'b1 || DONE !== 1'b0)) begin
        failures++;
        $display("FAIL mul_busy_edge_%0d: BUSY=%b DONE=%b, required 1 0", k, BUSY, DONE);
      end else if (k == 34 && (BUSY !== 1'b0 || DONE !== 1'b1 || RESULT !== 32'hFFFF_FFEB)) begin
        failures++;
        $display("FAIL mul_done_edge_34: BUSY=%b DONE=%b RESULT=%h, required 0 1 ffffffeb", BUSY, DONE, RESULT);
      end
    end
    wait_idle();
  endtask

  task automatic test_mul_high();
    run_expect(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    run_expect(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max_max");
    run_expect(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
  endtask

  task automatic test_div();
    run_expect(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg7_2");
    run_expect(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg7_2");
    run_expect(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run_expect(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
  endtask

  task automatic test_special();
    run_expect(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
    run_expect(3'b110, 32'd5, 32'd0, 32'd5, "rem_by_zero");
    run_expect(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    run_expect(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
  endtask

  task automatic test_flush();
    logic [W-1:0] prev;
    prev  = last_result;
    FUN3  = 3'b100;
    RS1   = 32'd1000;
    RS2   = 32'd3;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== prev) begin
      failures++;
      $display("FAIL flush_abort: BUSY=%b DONE=%b RESULT=%h, required 0 0 %h", BUSY, DONE, RESULT, prev);
    end
    run_expect(3'b101, 32'd1000, 32'd3, 32'd333, "after_flush_divu");
    FUN3  = 3'b000;
    RS1   = 32'd3;
    RS2   = 32'd3;
    START = 1'b1;
    FLUSH = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL start_with_flush: BUSY=%b, required 0", BUSY);
    end
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    FUN3  = 3'b000;
    RS1   = 32'd12345;
    RS2   = 32'd678;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (15) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_mid_calc: BUSY=%b DONE=%b RESULT=%h, required 0 0 0", BUSY, DONE, RESULT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    last_result = '0;
    repeat (40) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_no_resume: BUSY=%b RESULT=%h, required 0 0", BUSY, RESULT);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   e0;
    FUN3  = 3'b001;
    RS1   = 32'hFFFF_FF00;
    RS2   = 32'h0123_4567;
    START = 1'b1;
    e0 = cyc + 1;
    e.res = ref_op(3'b001, 32'hFFFF_FF00, 32'h0123_4567);
    e.edge_n = e0 + W + 2;
    e.f = 3'b001;
    sb.push_back(e);
    @(negedge CLK);
    // START stays high; these operands must only be taken in the IDLE cycle after DONE
    FUN3 = 3'b110;
    RS1  = 32'hFFFF_FC19;
    RS2  = 32'd17;
    e.res = ref_op(3'b110, 32'hFFFF_FC19, 32'd17);
    e.edge_n = e0 + W + 3 + W + 2;
    e.f = 3'b110;
    sb.push_back(e);
    repeat (W + 2) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle_cycle: BUSY=%b DONE=%b, required 0 1", BUSY, DONE);
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept: BUSY=%b, required 1", BUSY);
    end
    START = 1'b0;
    FUN3  = 3'b000;
    RS1   = $urandom;
    RS2   = $urandom;
    wait_idle();
  endtask

  task automatic test_random();
    logic [W-1:0] corners [4];
    logic [W-1:0] a, b;
    logic [2:0]   f;
    corners = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(7));
      a = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : $urandom;
      b = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : $urandom;
      issue(f, a, b);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mstd_unit.md
Name: mstd_unit

Overview:
- Iterative multiply/divide unit for the RV32M operations that decode marks as ALU_CNT = alu_mstd.
- Sits in the execute stage beside the ALU. Consumes the decoded FUN3 and the operand buses.
- Returns one 32-bit result after a fixed multi-cycle latency. Asserts BUSY so the pipeline can stall upstream stages.

Parameters:
- WIDTH, 32, operand and result width. Also the number of iteration cycles.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  op valid; sampled only in IDLE.
- FUN3  input  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- RS1  input  WIDTH  operand 1 (multiplicand or dividend).
- RS2  input  WIDTH  operand 2 (multiplier or divisor).
- FLUSH  input  1  synchronous abort of the current op.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse; RESULT is valid in the same cycle.
- RESULT  output  WIDTH  result, held until the next DONE.

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: BUSY=0, DONE=0, RESULT=0, state=IDLE, all internal registers 0. Reset mid-op aborts the op; no DONE follows.
- State machine: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE:
  - START=1 and FLUSH=0 latches FUN3, RS1, RS2 and moves to PREP.
  - BUSY rises in the next cycle.
- PREP (1 cycle):
  - Record the operand sign flags. RS1 is signed for mulh, mulhsu, div and rem. RS2 is signed for mulh, div and rem.
  - Replace each signed negative operand by its two's-complement magnitude.
  - Special cases go directly to FIX and skip CALC:
    - divisor == 0: quotient = all-ones; remainder = RS1 unmodified.
    - signed div/rem with RS1 = 0x80000000 and RS2 = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Otherwise load the iteration counter with WIDTH and go to CALC.
- CALC (exactly WIDTH cycles):
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first. Remainder register is WIDTH+1 bits.
  - The counter decrements each cycle. Go to FIX when it reaches 0.
- FIX (1 cycle):
  - Product sign = sign1 XOR sign2; negate the 64-bit product if set.
  - Quotient sign = sign1 XOR sign2. Remainder takes the sign of the dividend.
  - The negation rules do not apply to special-case results.
  - Select the low product word for mul; the high word for mulh, mulhsu and mulhu; the quotient for div and divu; the remainder for rem and remu.
  - Register RESULT, pulse DONE, drop BUSY in the same cycle, return to IDLE.
- Latency, with START sampled at edge 0:
  - Normal ops: DONE at edge WIDTH+2 (34 for WIDTH=32).
  - Special cases: DONE at edge 2.
- Back-to-back: START is accepted in the cycle after DONE (IDLE). START while BUSY=1 is ignored.
- FLUSH:
  - In any non-IDLE state, returns to IDLE at the next edge with BUSY=0 and no DONE. RESULT keeps its previous value.
  - START together with FLUSH in IDLE is not accepted; FLUSH wins.
- Operands are captured at acceptance. Changes on RS1/RS2/FUN3 while BUSY do not affect the result.

Test Plan:
- mul RS1=7, RS2=0xFFFFFFFD -> RESULT=0xFFFFFFEB. DONE pulses exactly at edge 34; BUSY=1 over edges 1..33.
- mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. rem of the same -> 0xFFFFFFFF. divu 100 / 7 -> 14. remu 100 / 7 -> 2.
- div 5 / 0 -> 0xFFFFFFFF at edge 2. rem 5 / 0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000. rem of the same -> 0.
- Abort and back-to-back:
  - FLUSH at edge 10 of a div -> BUSY=0 at edge 11, no DONE, RESULT unchanged.
  - A new START the next cycle completes normally.
  - RST_N low mid-CALC -> outputs 0 immediately.
- START held high across DONE -> the second op is accepted only in the IDLE cycle after DONE. Both results are correct; operand changes during BUSY are ignored.
